fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle core.
- Owns the fetch PC and issues word fetches to an instruction memory over a request/grant and in-order response interface.
- Buffers returned words in a DEPTH-entry prefetch queue and hands {instruction, pc} pairs to the core under valid/ready.
- Core-side redirects (branch, j, jal, jr) flush the queue and discard stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- mem_req_o  out  1  fetch request valid.
- mem_addr_o  out  32  fetch byte address; bits [1:0] always 0.
- mem_gnt_i  in  1  request accepted this cycle (counts only when mem_req_o=1).
- mem_rvalid_i  in  1  response valid; responses are in order, earliest one cycle after grant.
- mem_rdata_i  in  32  response instruction word.
- instr_valid_o  out  1  instr_o/pc_o are valid.
- instr_o  out  32  instruction word at queue head.
- pc_o  out  32  byte address of instr_o.
- instr_ready_i  in  1  core consumes the head this cycle.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  32  new fetch address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0.
  - Outputs: mem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=0. mem_addr_o=RESET_PC.
  - Reset overrides every other input in the same cycle. After a reset mid-operation, any late mem_rvalid_i is ignored only if discard covers it; the memory must be reset alongside.
- Credits: mem_req_o = !rst_i && !redirect_i && (count + outstanding < DEPTH). This guarantees the queue never overflows.
- mem_addr_o = fetch_pc, combinationally. mem_addr_o and mem_req_o hold stable until granted.
- Grant (mem_req_o && mem_gnt_i):
  - fetch_pc += 4, wrapping modulo 2^32.
  - outstanding += 1.
  - Push pc tag fetch_pc into a DEPTH-deep tag FIFO.
- Response (mem_rvalid_i):
  - outstanding -= 1.
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise write {mem_rdata_i, tag head} to the queue and pop the tag.
  - A response with outstanding==0 is a protocol error and is ignored.
- Pop (instr_valid_o && instr_ready_i): advance the head.
- Simultaneous push and pop update count unchanged; correct when full or when empty (empty case: see optional bypass).
- Output latency without bypass: a response is visible on instr_valid_o the cycle after mem_rvalid_i.
- Redirect (redirect_i=1):
  - Queue cleared and tag FIFO cleared.
  - discard = outstanding − (response this cycle ? 1 : 0), plus nothing extra because no request is issued this cycle.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - instr_valid_o forced 0 that cycle. Pop is ignored.
- Redirect and grant in the same cycle cannot occur, because mem_req_o=0 when redirect_i=1.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. outstanding and discard are each $clog2(DEPTH)+1 bits.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the queue is empty, discard==0, mem_rvalid_i=1 and no redirect, instr_o=mem_rdata_i, pc_o=tag head and instr_valid_o=1 in the same cycle (zero-latency).
  - If instr_ready_i=1, the word is not written to the queue; otherwise it is enqueued normally.
- Not defined: every response goes through the queue, with 1-cycle latency as specified above.

Test Plan:
- Reset with RESET_PC=0x100, gnt=1, 1-cycle response latency, ready=1 -> pc_o sequence 0x100, 0x104, 0x108, with matching instr_o; instr_valid_o stays 0 during and for 1 cycle after reset.
- Hold instr_ready_i=0, gnt=1 -> exactly DEPTH=4 grants, then mem_req_o=0; count=4 with no overflow. One pop -> mem_req_o=1 next cycle.
- With 3 outstanding, redirect_i=1, redirect_pc_i=0x2003 -> next mem_addr_o=0x2000; the 3 stale responses are dropped; first instr_valid_o has pc_o=0x2000.
- mem_gnt_i held 0 for 5 cycles -> mem_req_o stays 1 and mem_addr_o stays constant; no pc advance.
- fetch_pc=0xFFFF_FFFC, granted -> next mem_addr_o=0x0000_0000 (wrap).
- With FETCH_BYPASS_EN, empty queue, rvalid and ready both 1 -> instr_valid_o=1 in the same cycle as rvalid; without the macro, one cycle later.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: fetch PC, credit-limited request issue, tag FIFO and prefetch queue; FETCH_BYPASS_EN enables zero-latency empty-queue bypass
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   tag_pc  [DEPTH];
  logic [AW-1:0] q_head, q_tail, t_head, t_tail;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW:0]   used;
  logic          gnt, rsp, keep, byp, push, pop, has;
  always_comb begin
    used          = {1'b0, count} + {1'b0, outstanding};
    mem_req_o     = !rst_i && !redirect_i && (used < (CW+1)'(DEPTH));
    mem_addr_o    = fetch_pc;
    gnt           = mem_req_o && mem_gnt_i;
    rsp           = mem_rvalid_i && (outstanding != '0);
    keep          = rsp && (discard == '0);
    has           = !rst_i && !redirect_i && (count != '0);
`ifdef FETCH_BYPASS_EN
    byp           = !rst_i && !redirect_i && (count == '0) && keep;
`else
    byp           = 1'b0;
`endif
    push          = keep && !redirect_i && !(byp && instr_ready_i);
    pop           = has && instr_ready_i;
    instr_valid_o = has || byp;
    instr_o       = has ? q_instr[q_head] : byp ? mem_rdata_i : '0;
    pc_o          = has ? q_pc[q_head] : byp ? tag_pc[t_head] : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      q_head      <= '0;
      q_tail      <= '0;
      t_head      <= '0;
      t_tail      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_i) begin
      // every response still in flight belongs to the old stream
      fetch_pc    <= {redirect_pc_i[31:2], 2'b00};
      q_head      <= '0;
      q_tail      <= '0;
      t_head      <= '0;
      t_tail      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(rsp);
      discard     <= outstanding - CW'(rsp);
    end else begin
      if (gnt) begin
        fetch_pc       <= fetch_pc + 32'd4;
        tag_pc[t_tail] <= fetch_pc;
        t_tail         <= t_tail + 1'b1;
      end
      if (keep) t_head <= t_head + 1'b1;
      if (push) begin
        q_instr[q_tail] <= mem_rdata_i;
        q_pc[q_tail]    <= tag_pc[t_head];
        q_tail          <= q_tail + 1'b1;
      end
      if (pop) q_head <= q_head + 1'b1;
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(gnt) - CW'(rsp);
      if (rsp && !keep) discard <= discard - 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed checks of fetch, credits, redirect, stall, wrap and bypass latency
module tb_fetch_prefetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_rdata = '0;
  logic        instr_valid, instr_ready = 1'b0, redirect = 1'b0;
  logic [31:0] instr, pc, redirect_pc = '0;
  logic        resp_en = 1'b1;
  logic [31:0] pending [$];
  int          total = 0, bad = 0, gnt_cnt = 0;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk_i(clk), .rst_i(rst), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc),
    .instr_ready_i(instr_ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic        g;
    logic [31:0] a;
    g = mem_req && mem_gnt;
    a = mem_addr;
    @(posedge clk);
    #1;
    if (rst) pending.delete();
    else if (g) pending.push_back(a);
    if (!rst && resp_en && pending.size() > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word_at(pending.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    gnt_cnt += int'(g);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask
  task automatic first_valid(input string tag, input logic [31:0] exp_pc);
    int seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (instr_valid) begin
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_instr"}, instr, word_at(exp_pc));
        seen = 1;
      end else step();
    end
    chk({tag, "_seen"}, seen, 1);
  endtask
  initial begin
    int n;
    rst = 1'b1;
    mem_gnt = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    chk("rst_req", mem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_addr", mem_addr, 32'h100);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_valid", instr_valid, 0);
    chk("post_rst_req", mem_req, 1);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (instr_valid) begin
        chk("seq_pc", pc, 32'h100 + 32'(4 * n));
        chk("seq_instr", instr, word_at(32'h100 + 32'(4 * n)));
        n++;
      end
      step();
    end
    chk("seq_count", n, 3);
    // credit limit with a stalled core
    instr_ready = 1'b0;
    do_reset();
    gnt_cnt = 0;
    for (int i = 0; i < 8; i++) step();
    chk("full_grants", gnt_cnt, 4);
    chk("full_req", mem_req, 0);
    chk("full_valid", instr_valid, 1);
    chk("full_head", pc, 32'h100);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    #1;
    chk("pop_req", mem_req, 1);
    chk("pop_head", pc, 32'h104);
    // redirect with three responses in flight
    instr_ready = 1'b1;
    do_reset();
    resp_en = 1'b0;
    gnt_cnt = 0;
    step();
    step();
    step();
    chk("rd_outstanding", gnt_cnt, 3);
    redirect = 1'b1;
    redirect_pc = 32'h2003;
    #1;
    chk("rd_req", mem_req, 0);
    chk("rd_valid", instr_valid, 0);
    step();
    redirect = 1'b0;
    resp_en = 1'b1;
    #1;
    chk("rd_addr", mem_addr, 32'h2000);
    first_valid("rd_first", 32'h2000);
    // grant stall holds request and address
    mem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h4000;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'h4000);
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1;
    chk("stall_adv", mem_addr, 32'h4004);
    // address wrap
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_start", mem_addr, 32'hFFFF_FFFC);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1;
    chk("wrap_addr", mem_addr, 32'h0);
    first_valid("wrap_first", 32'hFFFF_FFFC);
    // response latency into an empty queue
    for (int i = 0; i < 6; i++) step();
    redirect = 1'b1;
    redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1;
    chk("lat_rvalid", mem_rvalid, 1);
    chk("lat_valid0", instr_valid, BYP ? 32'd1 : 32'd0);
    chk("lat_pc0", pc, BYP ? 32'h3000 : 32'h0);
    step();
    chk("lat_valid1", instr_valid, BYP ? 32'd0 : 32'd1);
    chk("lat_pc1", pc, BYP ? 32'h0 : 32'h3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
